// File: rtl/float_div_12.sv
// float_div_12: restoring divider for the 12-bit float {sgn, exp[4:0] bias 15, man[5:0] hidden 1}.
// Latency: accept edge to valid_o = MAN_W+3 edges (MAN_W+4 with FLOAT_DIV_12_ROUND_EN), fixed for all operands.
// Backpressure: one operation in flight; ready_o only in IDLE, result held in DONE until ready_i.
module float_div_12 #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 6,
    parameter int BIAS  = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [EXP_W+MAN_W:0]     data_1_i,
    input  logic [EXP_W+MAN_W:0]     data_2_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [EXP_W+MAN_W:0]     data_div_o,
    output logic                     div_zero_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
`ifdef FLOAT_DIV_12_ROUND_EN
    localparam int N = MAN_W + 3;   // extra iteration yields the guard bit
`else
    localparam int N = MAN_W + 2;
`endif
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]        LAST   = CW'(N - 1);
    localparam logic [EW-1:0]        BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]              state;
    logic                    sgn;
    logic signed [EW-1:0]    e_tmp;
    logic [MAN_W+1:0]        rem;
    logic [MAN_W:0]          dvs;
    logic [N-1:0]            q;
    logic [CW-1:0]           cnt;
    logic                    a_zero;
    logic                    b_zero;

    logic [EW-1:0]           e_acc;
    logic                    q_bit;
    logic [MAN_W+1:0]        rem_sub;
    logic [MAN_W+1:0]        rem_nxt;
    logic [MAN_W-1:0]        man_f;
    logic signed [EW-1:0]    e_f;
    logic [W-1:0]            res;
    logic                    res_dz;

    assign ready_o = (state == S_IDLE);

    // Exponent difference in EW-bit two's complement; wraps correctly for negative results.
    assign e_acc = {2'b00, data_1_i[W-2:MAN_W]} - {2'b00, data_2_i[W-2:MAN_W]} + BIAS_E;

    // One restoring step: subtract when the partial remainder covers the divisor, then shift.
    always_comb begin
        q_bit   = (rem >= {1'b0, dvs});
        rem_sub = q_bit ? (rem - {1'b0, dvs}) : rem;
        rem_nxt = rem_sub << 1;
    end

    // Normalise the quotient (value in [0.5,2)), optionally round, then apply special cases.
    always_comb begin
`ifdef FLOAT_DIV_12_ROUND_EN
        logic          guard;
        logic [MAN_W:0] man_r;
`endif
        man_f  = '0;
        e_f    = e_tmp;
        res    = '0;
        res_dz = 1'b0;
        if (q[N-1]) begin
            man_f = q[N-2 -: MAN_W];
            e_f   = e_tmp;
        end else begin
            man_f = q[N-3 -: MAN_W];
            e_f   = e_tmp - EW'(1);
        end
`ifdef FLOAT_DIV_12_ROUND_EN
        guard = q[N-1] ? q[N-2-MAN_W] : q[N-3-MAN_W];
        man_r = {1'b0, man_f} + {{MAN_W{1'b0}}, guard};
        man_f = man_r[MAN_W-1:0];
        // Carry-out leaves the mantissa at zero and bumps the exponent.
        if (man_r[MAN_W]) begin
            e_f = e_f + EW'(1);
        end
`endif
        if (a_zero) begin
            res = '0;
        end else if (b_zero) begin
            res    = {sgn, {(W-1){1'b1}}};
            res_dz = 1'b1;
        end else if (e_f > E_MAX) begin
            res = {sgn, {(W-1){1'b1}}};
        end else if (e_f <= 0) begin
            res = '0;
        end else begin
            res = {sgn, e_f[EXP_W-1:0], man_f};
        end
    end

    // Control FSM with operand capture, iteration state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            sgn        <= 1'b0;
            e_tmp      <= '0;
            rem        <= '0;
            dvs        <= '0;
            q          <= '0;
            cnt        <= '0;
            a_zero     <= 1'b0;
            b_zero     <= 1'b0;
            data_div_o <= '0;
            div_zero_o <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        state  <= S_DIV;
                        sgn    <= data_1_i[W-1] ^ data_2_i[W-1];
                        e_tmp  <= e_acc;
                        rem    <= {1'b0, 1'b1, data_1_i[MAN_W-1:0]};
                        dvs    <= {1'b1, data_2_i[MAN_W-1:0]};
                        q      <= '0;
                        cnt    <= '0;
                        a_zero <= (data_1_i[W-2:0] == '0);
                        b_zero <= (data_2_i[W-2:0] == '0);
                    end
                end
                S_DIV: begin
                    rem <= rem_nxt;
                    q   <= {q[N-2:0], q_bit};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    data_div_o <= res;
                    div_zero_o <= res_dz;
                    valid_o    <= 1'b1;
                    state      <= S_DONE;
                end
                default: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
